julia_iter_sched: RTL and testbench

//  Per-pixel escape-time sequencer for the Julia fractal renderer in the 720p HDMI pipeline.
//  - Accepts one (x,y) pixel request at a time.
//  - Seeds z0 from the pixel coordinates, then runs the shared julia_step datapath once per clock until |z|^2 escapes or MAX_ITS is reached.
//  - Returns the iteration count on a valid/ready result port.
//  - Sits between the pixel scheduler and the colour-palette lookup.

---
 rtl/julia_pkg.sv | 16 +
 rtl/julia_step.sv | 34 +++
 rtl/julia_iter_sched.sv | 147 ++++++++++++++
 tb/tb_julia_iter_sched.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/julia_pkg.sv
// Shared constants, default Julia constant and FSM state type for the escape-time sequencer.
package julia_pkg;

   localparam int          Q_FRAC     = 12;
   localparam logic [63:0] ESC_THRESH = 64'h400_0000;
   localparam logic [31:0] CX_DEF     = 32'h0000_0000;
   localparam logic [31:0] CY_DEF     = 32'h0000_1000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/julia_step.sv
// One combinational Julia iteration z' = z^2 + c in Q19.12, plus the |z'|^2 >= 4 escape test.
import julia_pkg::*;

module julia_step (
   input  logic signed [31:0] zx,
   input  logic signed [31:0] zy,
   input  logic signed [31:0] cx,
   input  logic signed [31:0] cy,
   output logic signed [31:0] zx1,
   output logic signed [31:0] zy1,
   output logic               esc
);

   logic signed [63:0] zx_w, zy_w, xx, yy, xy, dif_sh, xy_sh;
   logic signed [63:0] zx1_w, zy1_w, mag;

   always_comb begin
      zx_w   = zx;
      zy_w   = zy;
      xx     = zx_w * zx_w;
      yy     = zy_w * zy_w;
      xy     = zx_w * zy_w;
      dif_sh = (xx - yy) >>> Q_FRAC;
      // shifting one bit less folds the factor of two in 2*zx*zy
      xy_sh  = xy >>> (Q_FRAC - 1);
      zx1    = dif_sh[31:0] + cx;
      zy1    = xy_sh[31:0] + cy;
      zx1_w  = zx1;
      zy1_w  = zy1;
      mag    = zx1_w * zx1_w + zy1_w * zy1_w;
      esc    = (mag >= $signed(ESC_THRESH));
   end

endmodule

// File: rtl/julia_iter_sched.sv
// Per-pixel Julia escape-time sequencer: accept (x,y), iterate julia_step, return count.
// JULIA_ANIM_EN: when defined, c is taken from c_x/c_y at request acceptance; otherwise c = 0+1i.
import julia_pkg::*;

module julia_iter_sched #(
   parameter int ITS_W   = 4,
   parameter int MAX_ITS = 15,
   parameter int X_HALF  = 640,
   parameter int Y_HALF  = 360
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [10:0]      req_x,
   input  logic [10:0]      req_y,
`ifdef JULIA_ANIM_EN
   input  logic [31:0]      c_x,
   input  logic [31:0]      c_y,
`endif
   output logic             res_valid,
   input  logic             res_ready,
   output logic [ITS_W-1:0] res_its,
   output logic             busy
);

   localparam logic [ITS_W-1:0] CNT_LAST = ITS_W'(MAX_ITS - 1);
   localparam logic [ITS_W-1:0] ITS_MAX  = ITS_W'(MAX_ITS);

   state_t            state_q, state_d;
   logic [10:0]       x_q, x_d, y_q, y_d;
   logic [31:0]       zx_q, zx_d, zy_q, zy_d, cx_q, cx_d, cy_q, cy_d;
   logic [ITS_W-1:0]  cnt_q, cnt_d, res_its_q, res_its_d;
   logic              req_ready_q, req_ready_d, res_valid_q, res_valid_d, busy_q, busy_d;
   logic signed [31:0] zx1, zy1;
   logic              esc;
   logic [31:0]       cx_in, cy_in;

`ifdef JULIA_ANIM_EN
   assign cx_in = c_x;
   assign cy_in = c_y;
`else
   assign cx_in = CX_DEF;
   assign cy_in = CY_DEF;
`endif

   julia_step u_step (
      .zx  (zx_q),
      .zy  (zy_q),
      .cx  (cx_q),
      .cy  (cy_q),
      .zx1 (zx1),
      .zy1 (zy1),
      .esc (esc)
   );

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      zx_d        = zx_q;
      zy_d        = zy_q;
      cx_d        = cx_q;
      cy_d        = cy_q;
      cnt_d       = cnt_q;
      res_its_d   = res_its_q;
      req_ready_d = req_ready_q;
      res_valid_d = res_valid_q;
      busy_d      = busy_q;
      case (state_q)
         IDLE: if (req_valid && req_ready_q) begin
            x_d         = req_x;
            y_d         = req_y;
            cx_d        = cx_in;
            cy_d        = cy_in;
            state_d     = LOAD;
            req_ready_d = 1'b0;
            busy_d      = 1'b1;
         end
         LOAD: begin
            // two's-complement subtract then scale pixel units to 1/256 in Q.12
            zx_d    = (32'(x_q) - 32'(X_HALF)) << 4;
            zy_d    = (32'(y_q) - 32'(Y_HALF)) << 4;
            cnt_d   = '0;
            state_d = ITER;
         end
         ITER: begin
            if (esc) begin
               state_d     = DONE;
               res_its_d   = cnt_q;
               res_valid_d = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = DONE;
               res_its_d   = ITS_MAX;
               res_valid_d = 1'b1;
            end else begin
               zx_d  = zx1;
               zy_d  = zy1;
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: if (res_ready) begin
            state_d     = IDLE;
            res_valid_d = 1'b0;
            req_ready_d = 1'b1;
            busy_d      = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         zx_q        <= '0;
         zy_q        <= '0;
         cx_q        <= '0;
         cy_q        <= '0;
         cnt_q       <= '0;
         res_its_q   <= '0;
         req_ready_q <= 1'b1;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         zx_q        <= zx_d;
         zy_q        <= zy_d;
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         cnt_q       <= cnt_d;
         res_its_q   <= res_its_d;
         req_ready_q <= req_ready_d;
         res_valid_q <= res_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign req_ready = req_ready_q;
   assign res_valid = res_valid_q;
   assign res_its   = res_its_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_julia_iter_sched.sv
// Directed self-checking bench for julia_iter_sched (default c = 0+1i; c-port test under JULIA_ANIM_EN).
module tb_julia_iter_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [10:0] req_x = '0;
   logic [10:0] req_y = '0;
`ifdef JULIA_ANIM_EN
   logic [31:0] c_x = 32'h0;
   logic [31:0] c_y = 32'h1000;
`endif
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [3:0]  res_its;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   julia_iter_sched dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .req_y     (req_y),
`ifdef JULIA_ANIM_EN
      .c_x       (c_x),
      .c_y       (c_y),
`endif
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_its   (res_its),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Present one request; returns at 1 time unit after the acceptance edge.
   task automatic accept_req(input logic [10:0] x, input logic [10:0] y);
      req_x = x;
      req_y = y;
      req_valid = 1'b1;
      for (int t = 0; t < 50; t++) begin
         if (req_ready) begin
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
   endtask

   // Edges from acceptance until res_valid; -1 on timeout.
   task automatic wait_result(output int edges);
      edges = -1;
      for (int n = 1; n <= 100; n++) begin
         @(posedge clk); #1;
         if (res_valid) begin
            edges = n;
            break;
         end
      end
   endtask

   task automatic consume;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
      n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
      n_cmp++; if (res_its !== 4'd0) begin n_bad++; $display("FAIL reset_res_its got %0d want 0", res_its); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
   endtask

   task automatic test_corner;
      int e;
      accept_req(11'd0, 11'd0);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL corner_busy got %b want 1", busy); end
      wait_result(e);
      n_cmp++; if (e != 2) begin n_bad++; $display("FAIL corner_latency got %0d want 2", e); end
      n_cmp++; if (res_its !== 4'd0) begin n_bad++; $display("FAIL corner_its got %0d want 0", res_its); end
      consume();
      n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL corner_consumed got %b want 0", res_valid); end
   endtask

   task automatic test_centre;
      int e;
      accept_req(11'd640, 11'd360);
      wait_result(e);
      n_cmp++; if (e != 16) begin n_bad++; $display("FAIL centre_latency got %0d want 16", e); end
      n_cmp++; if (res_its !== 4'd15) begin n_bad++; $display("FAIL centre_its got %0d want 15", res_its); end
      consume();
   endtask

   task automatic test_backpressure;
      int e;
      accept_req(11'd0, 11'd0);
      wait_result(e);
      n_cmp++; if (e != 2) begin n_bad++; $display("FAIL bp_latency got %0d want 2", e); end
      for (int c = 0; c < 10; c++) begin
         if (c == 4) begin req_x = 11'd640; req_y = 11'd360; req_valid = 1'b1; end
         if (c == 5) req_valid = 1'b0;
         @(posedge clk); #1;
         n_cmp++; if (res_valid !== 1'b1 || res_its !== 4'd0 || req_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp_hold cyc %0d got valid=%b its=%0d rdy=%b want 1/0/0", c, res_valid, res_its, req_ready);
         end
      end
      consume();
      n_cmp++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_bad++; $display("FAIL bp_consume got valid=%b rdy=%b want 0/1", res_valid, req_ready);
      end
      repeat (3) @(posedge clk); #1;
      n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL bp_one_result got valid=%b busy=%b want 0/0", res_valid, busy);
      end
   endtask

   task automatic test_reset_mid;
      int e;
      accept_req(11'd640, 11'd360);
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_cmp++; if (req_ready !== 1'b1 || res_valid !== 1'b0 || res_its !== 4'd0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL midreset got rdy=%b valid=%b its=%0d busy=%b want 1/0/0/0", req_ready, res_valid, res_its, busy);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_no_result got %b want 0", res_valid); end
      accept_req(11'd0, 11'd0);
      wait_result(e);
      n_cmp++; if (e != 2 || res_its !== 4'd0) begin
         n_bad++; $display("FAIL midreset_next got lat=%0d its=%0d want 2/0", e, res_its);
      end
      consume();
   endtask

   task automatic test_back_to_back;
      int e;
      // Result handshake with a request already waiting: not accepted in the handshake cycle.
      accept_req(11'd0, 11'd0);
      wait_result(e);
      req_x = 11'd640; req_y = 11'd360; req_valid = 1'b1; res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      n_cmp++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
         n_bad++; $display("FAIL b2b_gap got rdy=%b busy=%b want 1/0", req_ready, busy);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_result(e);
      n_cmp++; if (e != 16 || res_its !== 4'd15) begin
         n_bad++; $display("FAIL b2b_second got lat=%0d its=%0d want 16/15", e, res_its);
      end
      consume();
   endtask

`ifdef JULIA_ANIM_EN
   task automatic test_anim;
      int e;
      c_x = 32'h3000; c_y = 32'h0;
      accept_req(11'd640, 11'd360);
      c_x = 32'h0; c_y = 32'h1000;
      wait_result(e);
      n_cmp++; if (e != 2 || res_its !== 4'd0) begin
         n_bad++; $display("FAIL anim_c3 got lat=%0d its=%0d want 2/0", e, res_its);
      end
      consume();
      accept_req(11'd640, 11'd360);
      wait_result(e);
      n_cmp++; if (e != 16 || res_its !== 4'd15) begin
         n_bad++; $display("FAIL anim_ci got lat=%0d its=%0d want 16/15", e, res_its);
      end
      consume();
   endtask
`endif

   initial begin
      test_reset();
      test_corner();
      test_centre();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
`ifdef JULIA_ANIM_EN
      test_anim();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
